// File: rtl/fir_frame_stats.sv
// ============================================================================
// Module      : fir_frame_stats
// Description : Per-frame max/min/sum/mean of the FIR output stream. The
//               optional settling-sample discard is enabled by defining
//               FIR_STATS_SKIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_frame_stats #(
    parameter int DATA_W    = 10,
    parameter int FRAME_LEN = 512,
    parameter int SKIP_LEN  = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [DATA_W-1:0]                  y,
    input  logic                               y_valid,
    input  logic                               clear,
    output logic [DATA_W-1:0]                  frame_max,
    output logic [DATA_W-1:0]                  frame_min,
    output logic [DATA_W+$clog2(FRAME_LEN)-1:0] frame_sum,
    output logic [DATA_W-1:0]                  frame_mean,
    output logic                               frame_done,
    output logic [15:0]                        frame_count
);

    localparam int c_IDX_W = $clog2(FRAME_LEN);
    localparam int c_SUM_W = DATA_W + c_IDX_W;
`ifdef FIR_STATS_SKIP_EN
    localparam int c_SKIP_CNT = SKIP_LEN;
`else
    localparam int c_SKIP_CNT = 0;
`endif
    localparam int c_SKIP_W = (SKIP_LEN > 1) ? $clog2(SKIP_LEN) : 1;

    typedef enum logic [0:0] {
        ST_SKIP  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // Entry state after reset/clear; SKIP is unreachable when the discard is off
    localparam state_t c_START = (c_SKIP_CNT > 0) ? ST_SKIP : ST_ACCUM;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_SKIP_W-1:0]   r_skip_cnt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [DATA_W-1:0]     r_run_max;
    logic [DATA_W-1:0]     r_run_min;
    logic [c_SUM_W-1:0]    r_run_sum;

    logic                  w_take;
    logic                  w_last;
    logic                  w_skip_done;
    logic [DATA_W-1:0]     w_max_nxt;
    logic [DATA_W-1:0]     w_min_nxt;
    logic [c_SUM_W-1:0]    w_sum_nxt;

    assign w_take      = (r_state == ST_ACCUM) && y_valid && !clear;
    assign w_last      = (r_idx == c_IDX_W'(FRAME_LEN - 1));
    assign w_skip_done = (r_skip_cnt == c_SKIP_W'(c_SKIP_CNT - 1));
    assign w_max_nxt   = (y > r_run_max) ? y : r_run_max;
    assign w_min_nxt   = (y < r_run_min) ? y : r_run_min;
    assign w_sum_nxt   = r_run_sum + c_SUM_W'(y);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = c_START;
        end else if ((r_state == ST_SKIP) && y_valid && w_skip_done) begin
            w_state_nxt = ST_ACCUM;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_skip_cnt <= '0;
        end else if (clear) begin
            r_skip_cnt <= '0;
        end else if ((r_state == ST_SKIP) && y_valid) begin
            r_skip_cnt <= r_skip_cnt + c_SKIP_W'(1);
        end
    end

    // Running accumulators: an empty frame is max=0, min=all ones, sum=0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx     <= '0;
            r_run_max <= '0;
            r_run_min <= '1;
            r_run_sum <= '0;
        end else if (clear || (w_take && w_last)) begin
            r_idx     <= '0;
            r_run_max <= '0;
            r_run_min <= '1;
            r_run_sum <= '0;
        end else if (w_take) begin
            r_idx     <= r_idx + c_IDX_W'(1);
            r_run_max <= w_max_nxt;
            r_run_min <= w_min_nxt;
            r_run_sum <= w_sum_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_max   <= '0;
            frame_min   <= '0;
            frame_sum   <= '0;
            frame_mean  <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            if (w_take && w_last) begin
                frame_max   <= w_max_nxt;
                frame_min   <= w_min_nxt;
                frame_sum   <= w_sum_nxt;
                frame_mean  <= w_sum_nxt[c_SUM_W-1:c_IDX_W];
                frame_done  <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/fir_frame_stats.md
Name: fir_frame_stats

Overview:
Downstream consumer of the FIR filter output. Accepts one filtered sample per valid cycle and groups samples into frames of FRAME_LEN. FRAME_LEN matches the 512-entry sample ROM sweep, so one frame is one full ROM pass. For each completed frame it publishes max, min, sum and mean, with a one-cycle done pulse and a frame counter, for bench checking and later on-chip readout.

Parameters:
DATA_W, 10, width of filter output sample y (unsigned)
FRAME_LEN, 512, samples per frame; must be a power of two, >= 2
SKIP_LEN, 8, settling samples discarded after reset/clear (used only when FIR_STATS_SKIP_EN is defined)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
y  input  DATA_W  filtered sample from FIR filter, unsigned
y_valid  input  1  y is valid this cycle; tie high for free-running ROM sweep
clear  input  1  synchronous: abandon current partial frame, restart count
frame_max  output  DATA_W  largest sample of last completed frame
frame_min  output  DATA_W  smallest sample of last completed frame
frame_sum  output  DATA_W+log2(FRAME_LEN)  sum of last completed frame (19 bits at defaults)
frame_mean  output  DATA_W  frame_sum >> log2(FRAME_LEN), truncating
frame_done  output  1  one-cycle pulse when frame results update
frame_count  output  16  completed frames since reset, wraps 65535->0

Behaviour:
- Single clock domain: clock. Reset is asynchronous and active-high. All outputs and internal state clear immediately on reset assertion, without waiting for a clock edge.
- Reset values: frame_max/min/sum/mean = 0, frame_done = 0, frame_count = 0, sample index = 0, running max = 0, running min = all ones, running sum = 0.
- States: SKIP (only when macro defined) and ACCUM. Reset and clear enter SKIP if enabled, otherwise ACCUM.
- ACCUM accepts a sample on any edge where y_valid=1. Each accepted sample updates running max/min/sum and increments index 0..FRAME_LEN-1.
- Frame completion happens at the edge that accepts the sample with index FRAME_LEN-1. At that edge:
  - Output registers load the final values, including that last sample.
  - frame_done=1 for exactly that following cycle.
  - frame_count increments.
  - Running accumulators reload as if empty; index returns to 0.
- Back-to-back frames: the next valid sample is index 0 of the new frame. No gap cycle is required, and no sample is lost.
- y_valid=0: no state change except frame_done returning to 0.
- Outputs hold their values between frame_done pulses.
- Sum width is DATA_W+log2(FRAME_LEN), so all-full-scale input cannot overflow.
- Mean is truncating division by shift. There is no rounding.
- clear=1 at an edge:
  - Index goes to 0 and accumulators reload empty.
  - Outputs and frame_count are unchanged; no frame_done.
  - clear has priority over a simultaneous valid sample, which is dropped.
- clear on the completing edge: clear wins, the frame is discarded, and frame_done is not asserted.

Optional Feature:
FIR_STATS_SKIP_EN
- Defined: after reset or clear, the block sits in SKIP. The first SKIP_LEN valid samples are discarded and do not enter statistics; this hides FIR pipeline fill. The block then moves to ACCUM and never re-enters SKIP until the next reset or clear.
- Not defined: there is no SKIP state, the first valid sample after reset/clear is frame index 0, and SKIP_LEN is ignored.

Test Plan:
1. Macro off, y=100, y_valid=1 for 512 cycles -> frame_done pulses once after 512th edge; max=min=mean=100, sum=51200, frame_count=1.
2. Ramp y=0..511, then 512..1023 -> frame 1: max 511, min 0, sum 130816, mean 255. Frame 2: max 1023, min 512, sum 392960, mean 767. frame_count=2, no gap between frames.
3. y=1023 for 512 valid cycles with y_valid alternating 1/0 -> done after 1023 cycles; sum=523776, mean=1023, no overflow.
4. Clear after 300 samples of y=50, then 512 samples of y=9 -> only one done pulse, with sum=4608, max=min=9; frame_count=1.
5. Reset asserted asynchronously mid-frame (between edges) -> all outputs read 0 before next clock edge; a full frame afterwards gives correct statistics.
6. Macro on, SKIP_LEN=8: 8 samples of y=1000, then 512 samples of y=5 -> max=min=5, sum=2560, done after the 520th valid sample.
